// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, status bit positions and the
// multiply sequencer's FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SR  = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;

    // Positions within the ALU status word {V,C,N,Z}
    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 32x32 unsigned multiplier (low word + overflow flag) that
// borrows the shared ALU as its adder. Optional ALU_MUL_EARLY_TERM_EN stops
// iterating as soon as the remaining multiplier bits are all zero.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_f,
    input  logic [3:0]       alu_status
);

    // Handshake: start is accepted on a rising edge only while ready=1; done
    // pulses for one cycle with result/ovf valid, which then hold until the
    // next accepted start.

    mul_state_t       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;

    logic [WIDTH-1:0] acc_nxt;
    logic             ovf_nxt;
    logic             last_iter;
    logic             mplr_empty;
    logic             unused_status;

    assign alu_a   = acc;
    assign alu_b   = mcand;
    assign alu_sel = ALU_ADD;

    assign unused_status = ^{alu_status[ST_V], alu_status[ST_N], alu_status[ST_Z]};

    // Overflow comes either from a carry out of the add or from a set
    // multiplicand bit that would be shifted away while multiplier bits remain.
    always_comb begin
        acc_nxt = mplr[0] ? alu_f : acc;
        ovf_nxt = ovf_acc
                | (mplr[0] & alu_status[ST_C])
                | (mcand[WIDTH-1] & (mplr[WIDTH-1:1] != '0));
    end

`ifdef ALU_MUL_EARLY_TERM_EN
    assign mplr_empty = (mplr == '0);
    assign last_iter  = 1'b0;
`else
    assign mplr_empty = 1'b0;
    assign last_iter  = (cnt == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc     <= '0;
                        mcand   <= op_a;
                        mplr    <= op_b;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        ready   <= 1'b0;
                        state   <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (mplr_empty) begin
                        result <= acc;
                        ovf    <= ovf_acc;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        acc     <= acc_nxt;
                        ovf_acc <= ovf_nxt;
                        mcand   <= mcand << 1;
                        mplr    <= mplr >> 1;
                        cnt     <= cnt + 1'b1;
                        if (last_iter) begin
                            result <= acc_nxt;
                            ovf    <= ovf_nxt;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ADD-only ALU beside the DUT, directed
// table, hand-written busy/reset sequences and random operands.
module tb_alu_mul_seq;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             ovf;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_f;
    logic [3:0]       alu_status;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .ready(ready), .done(done), .result(result), .ovf(ovf),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_status(alu_status)
    );

    // Shared ALU stand-in: only ADD produces a value, other selects give zero.
    logic [WIDTH:0] sum;
    always_comb begin
        sum        = '0;
        alu_f      = '0;
        alu_status = '0;
        if (alu_sel == 4'b0000) begin
            sum        = {1'b0, alu_a} + {1'b0, alu_b};
            alu_f      = sum[WIDTH-1:0];
            alu_status = {(alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != alu_a[WIDTH-1]),
                          sum[WIDTH], sum[WIDTH-1], sum[WIDTH-1:0] == '0};
        end
    end

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference model: plain 64-bit product.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] p;
        p = 64'(a) * 64'(b);
        return {|p[2*WIDTH-1:WIDTH], p[WIDTH-1:0]};
    endfunction

    // Edges from the accepting edge until done is visible.
    function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef ALU_MUL_EARLY_TERM_EN
        int k;
        k = 0;
        for (int i = 0; i < WIDTH; i++) if (b[i]) k = i + 1;
        return k + 1;
`else
        return WIDTH;
`endif
    endfunction

    // Driver: issue one operation, watch a window past done, optionally
    // poke start while busy.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int poke_at, output int lat,
                         output logic [WIDTH-1:0] res, output logic ov, output int dones);
        int n;
        lat = -1; dones = 0; res = '0; ov = 1'b0; n = 0;
        while (!ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_start", {63'd0, ready}, 64'd1);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom;
        for (int i = 1; i <= WIDTH + 6; i++) begin
            if (i == poke_at) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = i; res = result; ov = ovf;
                end
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int poke_at);
        int lat, dones;
        logic [WIDTH-1:0] res;
        logic ov;
        logic [WIDTH:0] m;
        m = model(a, b);
        do_op(a, b, poke_at, lat, res, ov, dones);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(b)));
        chk({tag, "_result"}, 64'(res), 64'(m[WIDTH-1:0]));
        chk({tag, "_ovf"}, 64'(ov), 64'(m[WIDTH]));
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
        chk({tag, "_held"}, {31'd0, ovf, result}, {31'd0, m[WIDTH], m[WIDTH-1:0]});
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             ov;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, dones, seen;
        logic [WIDTH-1:0] res, ra, rb;
        logic ov;
        logic [WIDTH:0] m;

        vecs[0] = '{32'd6,          32'd7,          32'd42,         1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1};
        vecs[2] = '{32'h0001_0000,  32'h0001_0000,  32'h0,          1'b1};
        vecs[3] = '{32'h0000_FFFF,  32'h0000_FFFF,  32'hFFFE_0001,  1'b0};
        vecs[4] = '{32'd5,          32'd3,          32'd15,         1'b0};
        vecs[5] = '{32'h1234_5678,  32'd0,          32'd0,          1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};
        vecs[7] = '{32'h8000_0000,  32'd2,          32'h0,          1'b1};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        chk("reset_alu_a", 64'(alu_a), 64'd0);
        chk("reset_alu_b", 64'(alu_b), 64'd0);
        chk("alu_sel_add", 64'(alu_sel), 64'd0);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, lat, res, ov, dones);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].b)));
            chk($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
            chk($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ov));
            chk($sformatf("vec%0d_done_pulses", i), 64'(dones), 64'd1);
            chk($sformatf("vec%0d_ready_after", i), 64'(ready), 64'd1);
        end

        // start while busy must be ignored
        run_and_check("busy_start", 32'd3, 32'd4, 5);

        // reset mid-operation aborts without a done pulse
        op_a = 32'h0000_FFFF; op_b = 32'h8000_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_busy", 64'(ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_and_check("after_abort", 32'd5, 32'd5, 0);

        // random operands across magnitude classes
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = 32'($urandom_range(0, 255)); rb = 32'($urandom_range(0, 255)); end
                1: begin ra = 32'($urandom_range(0, 65535)); rb = 32'($urandom_range(0, 65535)); end
                2: begin ra = $urandom; rb = $urandom; end
                default: begin ra = 32'd1 << $urandom_range(0, 31); rb = $urandom; end
            endcase
            m = model(ra, rb);
            do_op(ra, rb, ($urandom_range(0, 3) == 0) ? 3 : 0, lat, res, ov, dones);
            chk($sformatf("rand%0d_result a=%0h b=%0h", i, ra, rb), 64'(res), 64'(m[WIDTH-1:0]));
            chk($sformatf("rand%0d_ovf a=%0h b=%0h", i, ra, rb), 64'(ov), 64'(m[WIDTH]));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(exp_lat(rb)));
            chk($sformatf("rand%0d_done_pulses", i), 64'(dones), 64'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
